// File: rtl/hazard_forward_unit_pkg.sv
// ----------------------------------------------------------------------------
// Shared types for the rv32i hazard/forwarding controller.
//   forward              : ALU operand forward select consumed by the EX muxes
//   rv32i_types          : in-flight destination tag and the NOP tag constant
//   hazard_forward_unit_pkg : small helpers for building and testing tags
// ----------------------------------------------------------------------------
package forward;
    typedef enum logic [1:0] {
        from_idex  = 2'b00,   // operand straight from the ID/EX register
        from_exmem = 2'b01,   // bypass from the EX/MEM register
        from_memwb = 2'b10    // bypass from the MEM/WB register
    } forward_t;
endpackage

package rv32i_types;
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       is_load;
    } hazard_tag_t;

    localparam hazard_tag_t HAZARD_TAG_NOP = '0;
endpackage

package hazard_forward_unit_pkg;
    import rv32i_types::*;

    // A tag can feed a bypass only if it is a real instruction writing a
    // register other than x0.
    function automatic logic tag_live(input hazard_tag_t t);
        return t.valid & t.regwrite & (t.rd != 5'd0);
    endfunction

    function automatic hazard_tag_t make_tag(input logic [4:0] rd,
                                             input logic       regwrite,
                                             input logic       is_load);
        hazard_tag_t t;
        t.valid    = 1'b1;
        t.rd       = rd;
        t.regwrite = regwrite;
        t.is_load  = is_load;
        return t;
    endfunction
endpackage

// File: rtl/hazard_forward_unit_if.sv
// ----------------------------------------------------------------------------
// Bundle between the pipeline and hazard_forward_unit.
//   master : the pipeline side (drives ID info, stall/flush requests)
//   slave  : the hazard unit (drives forward selects, stall/bubble/flush, cnts)
// ----------------------------------------------------------------------------
interface hazard_forward_unit_if #(
    parameter int CNT_W = 32
);
    logic              id_valid;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic [4:0]        id_rd;
    logic              id_regwrite;
    logic              id_is_load;
    logic              mem_stall;
    logic              flush;

    forward::forward_t alumux1_fw;
    forward::forward_t alumux2_fw;
    logic              stall_if;
    logic              stall_id;
    logic              bubble_ex;
    logic              flush_ifid;
    logic [CNT_W-1:0]  load_use_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_rd, id_regwrite, id_is_load, mem_stall, flush,
        input  alumux1_fw, alumux2_fw, stall_if, stall_id, bubble_ex,
               flush_ifid, load_use_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_rd, id_regwrite, id_is_load, mem_stall, flush,
        output alumux1_fw, alumux2_fw, stall_if, stall_id, bubble_ex,
               flush_ifid, load_use_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_forward_unit_fw_select.sv
// ----------------------------------------------------------------------------
// fw_select: forward select for one ID source operand.
//   src_i, uses_i        : source register index and whether it is read
//   ex_live_i, ex_rd_i   : liveness and rd of the tag now in EX
//   mem_live_i, mem_rd_i : liveness and rd of the tag now in MEM
//   sel_o                : select the operand will need once it reaches EX
// ----------------------------------------------------------------------------
module fw_select (
    input  logic [4:0]        src_i,
    input  logic              uses_i,
    input  logic              ex_live_i,
    input  logic [4:0]        ex_rd_i,
    input  logic              mem_live_i,
    input  logic [4:0]        mem_rd_i,
    output forward::forward_t sel_o
);
    // The producer in EX now sits in EX/MEM when this operand reaches EX,
    // and it is newer than the one in MEM, so it is checked first.
    always_comb begin
        sel_o = forward::from_idex;
        if (uses_i && (src_i != 5'd0)) begin
            if (ex_live_i && (src_i == ex_rd_i)) begin
                sel_o = forward::from_exmem;
            end else if (mem_live_i && (src_i == mem_rd_i)) begin
                sel_o = forward::from_memwb;
            end
        end
    end
endmodule

// File: rtl/hazard_forward_unit.sv
// ----------------------------------------------------------------------------
// hazard_forward_unit: hazard controller for the 5-stage rv32i core.
// Tracks destination tags in EX/MEM/WB, registers forward selects into the
// ID/EX packet, detects load-use hazards, and applies flushes and freezes.
//   clk, rst : core clock, asynchronous active-high reset
//   hif      : slave side of hazard_forward_unit_if (ID info, mem_stall,
//              flush in; forward selects, stall/bubble/flush, counters out)
// ----------------------------------------------------------------------------
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
    import rv32i_types::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_forward_unit_if.slave hif
);
    hazard_tag_t       tag_ex_q,  tag_ex_d;
    hazard_tag_t       tag_mem_q, tag_mem_d;
    hazard_tag_t       tag_wb_q,  tag_wb_d;
    forward::forward_t fw1_q, fw1_d;
    forward::forward_t fw2_q, fw2_d;
    logic [CNT_W-1:0]  lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0]  fl_cnt_q, fl_cnt_d;

    logic              ex_live;
    logic              mem_live;
    logic              lu;
    logic              bubble;
    forward::forward_t fw1_sel;
    forward::forward_t fw2_sel;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign ex_live  = tag_live(tag_ex_q);
    assign mem_live = tag_live(tag_mem_q);

    // A flush discards the ID instruction, so it cannot cause a load-use stall.
    assign lu = hif.id_valid & ~hif.flush & ex_live & tag_ex_q.is_load &
                ((hif.id_uses_rs1 & (hif.id_rs1 == tag_ex_q.rd)) |
                 (hif.id_uses_rs2 & (hif.id_rs2 == tag_ex_q.rd)));

    // During a freeze nothing advances, so no bubble is inserted either.
    assign bubble = (lu | hif.flush) & ~hif.mem_stall;

    assign hif.stall_if     = lu | hif.mem_stall;
    assign hif.stall_id     = lu | hif.mem_stall;
    assign hif.bubble_ex    = bubble;
    assign hif.flush_ifid   = hif.flush & ~hif.mem_stall;
    assign hif.alumux1_fw   = fw1_q;
    assign hif.alumux2_fw   = fw2_q;
    assign hif.load_use_cnt = lu_cnt_q;
    assign hif.flush_cnt    = fl_cnt_q;

    fw_select u_fw1 (
        .src_i      (hif.id_rs1),
        .uses_i     (hif.id_uses_rs1),
        .ex_live_i  (ex_live),
        .ex_rd_i    (tag_ex_q.rd),
        .mem_live_i (mem_live),
        .mem_rd_i   (tag_mem_q.rd),
        .sel_o      (fw1_sel)
    );

    fw_select u_fw2 (
        .src_i      (hif.id_rs2),
        .uses_i     (hif.id_uses_rs2),
        .ex_live_i  (ex_live),
        .ex_rd_i    (tag_ex_q.rd),
        .mem_live_i (mem_live),
        .mem_rd_i   (tag_mem_q.rd),
        .sel_o      (fw2_sel)
    );

    always_comb begin
        tag_ex_d  = tag_ex_q;
        tag_mem_d = tag_mem_q;
        tag_wb_d  = tag_wb_q;
        fw1_d     = fw1_q;
        fw2_d     = fw2_q;
        lu_cnt_d  = lu_cnt_q;
        fl_cnt_d  = fl_cnt_q;
        if (!hif.mem_stall) begin
            tag_wb_d  = tag_mem_q;
            tag_mem_d = tag_ex_q;
            tag_ex_d  = (bubble || !hif.id_valid) ? HAZARD_TAG_NOP
                      : make_tag(hif.id_rd, hif.id_regwrite, hif.id_is_load);
            fw1_d     = bubble ? forward::from_idex : fw1_sel;
            fw2_d     = bubble ? forward::from_idex : fw2_sel;
            if (lu) begin
                lu_cnt_d = sat_inc(lu_cnt_q);
            end
            if (hif.flush) begin
                fl_cnt_d = sat_inc(fl_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_ex_q  <= HAZARD_TAG_NOP;
            tag_mem_q <= HAZARD_TAG_NOP;
            tag_wb_q  <= HAZARD_TAG_NOP;
            fw1_q     <= forward::from_idex;
            fw2_q     <= forward::from_idex;
            lu_cnt_q  <= '0;
            fl_cnt_q  <= '0;
        end else begin
            tag_ex_q  <= tag_ex_d;
            tag_mem_q <= tag_mem_d;
            tag_wb_q  <= tag_wb_d;
            fw1_q     <= fw1_d;
            fw2_q     <= fw2_d;
            lu_cnt_q  <= lu_cnt_d;
            fl_cnt_q  <= fl_cnt_d;
        end
    end

    // The WB tag is the retiring instruction: it must be exactly what MEM
    // held on the previous unfrozen edge.
    a_wb_follows_mem: assert property (
        @(posedge clk) disable iff (rst)
        !hif.mem_stall |=> (tag_wb_q == $past(tag_mem_q))
    );
endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;
    import forward::*;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int IDEX  = 0;
    localparam int EXMEM = 1;
    localparam int MEMWB = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    hazard_forward_unit_if #(.CNT_W(CW)) hif ();
    hazard_forward_unit #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .hif(hif));

    always #5 clk = ~clk;

    // Reference pipeline: slot 0 = EX, 1 = MEM, 2 = WB.
    bit m_v[3];
    int m_rd[3];
    bit m_wr[3];
    bit m_ld[3];
    int m_fw1, m_fw2, m_lu, m_fl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 0; m_rd[i] = 0; m_wr[i] = 0; m_ld[i] = 0;
        end
        m_fw1 = IDEX; m_fw2 = IDEX; m_lu = 0; m_fl = 0;
    endfunction

    function automatic bit writes(int slot, int r);
        return m_v[slot] && m_wr[slot] && (m_rd[slot] == r) && (r != 0);
    endfunction

    // Search in-flight producers newest first; EX producer is in EX/MEM later.
    function automatic int exp_sel(bit used, int r);
        if (!used || r == 0) return IDEX;
        for (int s = 0; s < 2; s++)
            if (writes(s, r)) return (s == 0) ? EXMEM : MEMWB;
        return IDEX;
    endfunction

    function automatic bit exp_lu();
        if (!hif.id_valid || hif.flush) return 0;
        if (!m_ld[0]) return 0;
        return (hif.id_uses_rs1 && writes(0, int'(hif.id_rs1))) ||
               (hif.id_uses_rs2 && writes(0, int'(hif.id_rs2)));
    endfunction

    function automatic void model_edge();
        bit lu, bub;
        int n1, n2;
        if (rst) begin model_reset(); return; end
        if (hif.mem_stall) return;
        lu  = exp_lu();
        bub = lu || hif.flush;
        n1  = bub ? IDEX : exp_sel(hif.id_uses_rs1, int'(hif.id_rs1));
        n2  = bub ? IDEX : exp_sel(hif.id_uses_rs2, int'(hif.id_rs2));
        if (lu && m_lu < CMAX) m_lu++;
        if (hif.flush && m_fl < CMAX) m_fl++;
        for (int s = 2; s > 0; s--) begin
            m_v[s] = m_v[s-1]; m_rd[s] = m_rd[s-1]; m_wr[s] = m_wr[s-1]; m_ld[s] = m_ld[s-1];
        end
        m_v[0]  = hif.id_valid && !bub;
        m_rd[0] = int'(hif.id_rd);
        m_wr[0] = hif.id_regwrite;
        m_ld[0] = hif.id_is_load;
        m_fw1 = n1; m_fw2 = n2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic set_id(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit wr, bit ld);
        hif.id_valid    = v;
        hif.id_rs1      = 5'(rs1);
        hif.id_uses_rs1 = u1;
        hif.id_rs2      = 5'(rs2);
        hif.id_uses_rs2 = u2;
        hif.id_rd       = 5'(rd);
        hif.id_regwrite = wr;
        hif.id_is_load  = ld;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Per-cycle compare against the reference model.
    always @(negedge clk) begin
        bit lu;
        lu = exp_lu();
        chk("stall_if",     hif.stall_if,     lu || hif.mem_stall);
        chk("stall_id",     hif.stall_id,     lu || hif.mem_stall);
        chk("bubble_ex",    hif.bubble_ex,    (lu || hif.flush) && !hif.mem_stall);
        chk("flush_ifid",   hif.flush_ifid,   hif.flush && !hif.mem_stall);
        chk("alumux1_fw",   hif.alumux1_fw,   m_fw1);
        chk("alumux2_fw",   hif.alumux2_fw,   m_fw2);
        chk("load_use_cnt", hif.load_use_cnt, m_lu);
        chk("flush_cnt",    hif.flush_cnt,    m_fl);
    end

    initial begin
        rst = 1'b1;
        hif.mem_stall = 1'b0;
        hif.flush     = 1'b0;
        idle();
        model_reset();
        tick();
        tick();
        hif.mem_stall = 1'b1;
        #1;
        chk("rst_stall_follows_mem", hif.stall_id, 1);
        chk("rst_fw1", hif.alumux1_fw, IDEX);
        chk("rst_cnt", hif.load_use_cnt, 0);
        hif.mem_stall = 1'b0;
        tick();
        rst = 1'b0;

        // add x5 in EX, ID reads x5
        set_id(1, 0, 0, 0, 0, 5, 1, 0);
        tick();
        set_id(1, 5, 1, 0, 0, 8, 1, 0);
        #1 chk("s1_nostall", hif.stall_id, 0);
        tick();
        idle();
        #1 chk("s1_fw1_exmem", hif.alumux1_fw, EXMEM);

        // x6 in MEM, x5 in EX
        set_id(1, 0, 0, 0, 0, 6, 1, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 5, 1, 0);
        tick();
        set_id(1, 5, 1, 6, 1, 9, 1, 0);
        tick();
        idle();
        #1 chk("s2_fw1_exmem", hif.alumux1_fw, EXMEM);
        chk("s2_fw2_memwb", hif.alumux2_fw, MEMWB);

        // both EX and MEM write x5: newest wins
        set_id(1, 0, 0, 0, 0, 5, 1, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 5, 1, 0);
        tick();
        set_id(1, 5, 1, 0, 0, 9, 1, 0);
        tick();
        idle();
        #1 chk("s2_newest_wins", hif.alumux1_fw, EXMEM);

        // lw x7; add x8,x7,x1
        set_id(1, 0, 0, 0, 0, 7, 1, 1);
        tick();
        set_id(1, 7, 1, 1, 1, 8, 1, 0);
        #1 chk("s3_stall_if", hif.stall_if, 1);
        chk("s3_stall_id", hif.stall_id, 1);
        chk("s3_bubble", hif.bubble_ex, 1);
        tick();
        #1 chk("s3_lu_cnt", hif.load_use_cnt, 1);
        chk("s3_released", hif.stall_id, 0);
        tick();
        idle();
        #1 chk("s3_fw1_memwb", hif.alumux1_fw, MEMWB);

        // x0 never forwards or stalls
        set_id(1, 0, 0, 0, 0, 0, 1, 1);
        tick();
        set_id(1, 0, 1, 0, 0, 3, 1, 0);
        #1 chk("s4_nostall", hif.stall_id, 0);
        tick();
        idle();
        #1 chk("s4_fw1_idex", hif.alumux1_fw, IDEX);

        // flush beats load-use
        set_id(1, 0, 0, 0, 0, 9, 1, 1);
        tick();
        set_id(1, 9, 1, 0, 0, 4, 1, 0);
        hif.flush = 1'b1;
        #1 chk("s5_bubble", hif.bubble_ex, 1);
        chk("s5_flush_ifid", hif.flush_ifid, 1);
        chk("s5_stall_id", hif.stall_id, 0);
        tick();
        hif.flush = 1'b0;
        idle();
        #1 chk("s5_flush_cnt", hif.flush_cnt, 1);
        chk("s5_lu_unchanged", hif.load_use_cnt, 1);

        // lw x10 reading x9 (x9 now in MEM), then freeze with a load-use pending
        set_id(1, 9, 1, 0, 0, 10, 1, 1);
        tick();
        set_id(1, 10, 1, 0, 0, 11, 1, 0);
        hif.mem_stall = 1'b1;
        #1 chk("s6_fw1_before", hif.alumux1_fw, MEMWB);
        for (int c = 0; c < 3; c++) begin
            tick();
            #1 chk("s6_stall_id", hif.stall_id, 1);
            chk("s6_bubble", hif.bubble_ex, 0);
            chk("s6_fw1_hold", hif.alumux1_fw, MEMWB);
            chk("s6_lu_hold", hif.load_use_cnt, 1);
            chk("s6_fl_hold", hif.flush_cnt, 1);
        end
        tick();
        rst = 1'b1;
        model_reset();
        #1 chk("s6_rst_fw1", hif.alumux1_fw, IDEX);
        chk("s6_rst_lu", hif.load_use_cnt, 0);
        chk("s6_rst_fl", hif.flush_cnt, 0);
        hif.mem_stall = 1'b0;
        tick();
        rst = 1'b0;
        #1 chk("s6_no_pending_stall", hif.stall_id, 0);

        // randomized traffic; small register range for frequent hazards
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst = ($urandom_range(0, 299) == 0);
            if (rst) model_reset();
            set_id($urandom_range(0, 99) < 85,
                   $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0);
            hif.mem_stall = ($urandom_range(0, 5) == 0);
            hif.flush     = ($urandom_range(0, 7) == 0);
        end
        tick();
        rst = 1'b0;
        hif.mem_stall = 1'b0;
        hif.flush = 1'b0;
        idle();
        tick();
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Pipeline hazard controller for the 5-stage rv32i core. Keeps a shadow copy of the destination-register tags in flight in EX, MEM and WB. From those tags it produces the per-operand `forward::forward_t` selects consumed by the EX stage's ALU input muxes. It also detects load-use hazards, inserts bubbles, applies branch flushes and honours memory freezes. It sits beside the ID/EX pipeline register; its registered forward selects land in the ID/EX control packet on the same edge as the instruction they describe.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters

Ports:
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high. Ports are `clk` and `rst`.
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  5 each  ID source register indices
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads that source
- id_rd  in  5  ID destination register
- id_regwrite  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- mem_stall  in  1  I-cache or D-cache not ready; the whole pipe freezes
- flush  in  1  EX resolved a taken branch or jump; the ID and IF contents are wrong-path
- alumux1_fw, alumux2_fw  out  forward::forward_t  registered selects for the instruction currently in EX
- stall_if, stall_id  out  1 each  hold the PC and IF/ID registers
- bubble_ex  out  1  load a NOP into ID/EX
- flush_ifid  out  1  clear IF/ID
- load_use_cnt, flush_cnt  out  CNT_W each  performance counters

## Operation
- Tag format: {valid, rd, regwrite, is_load}. There are three tag registers: tag_ex, tag_mem, tag_wb.
- A tag is "live" when valid=1, regwrite=1 and rd!=0.
- Load-use hazard (lu), combinational: id_valid & !flush & tag_ex live & tag_ex.is_load, together with either:
  - id_uses_rs1 & id_rs1==tag_ex.rd, or
  - id_uses_rs2 & id_rs2==tag_ex.rd.
- Combinational outputs:
  - stall_if = stall_id = lu | mem_stall
  - bubble_ex = (lu | flush) & !mem_stall
  - flush_ifid = flush & !mem_stall
- Forward select for each operand n (computed against the tags before the clock edge):
  - from_exmem if the ID source matches tag_ex.rd and tag_ex is live. This instruction will be in MEM next cycle.
  - else from_memwb if the source matches tag_mem.rd and tag_mem is live.
  - else from_idex.
  - The newest producer wins.
  - A source not used, or register x0, always gives from_idex.
  - WB-to-ID forwarding is not handled here; the regfile is write-first.
- Clock edge when mem_stall=1: every register holds, including the selects and counters. flush and lu are ignored for that cycle; EX keeps flush asserted until the freeze ends.
- Clock edge when mem_stall=0:
  - tag_wb <= tag_mem
  - tag_mem <= tag_ex
  - tag_ex <= invalid if bubble_ex or !id_valid; otherwise the ID tag
  - alumux*_fw <= computed select, or from_idex when bubble_ex=1
  - load_use_cnt increments on lu; flush_cnt increments on flush. Both saturate at all-ones.
- Priority: mem_stall > flush > lu. A flush suppresses lu because the ID instruction is discarded.

## Timing
- Reset (asynchronous, immediate): all tags invalid, both fw selects = from_idex, both counters 0.
- While rst=1 the combinational outputs follow the rules above with invalid tags. stall_* therefore equals mem_stall.
- Select latency: 1 cycle, ID-cycle compare to EX-cycle output. The select is valid for the whole cycle the instruction is in EX.
- Load-use: exactly one stall cycle. On the next cycle the load is in MEM, so the dependent instruction then sees tag_ex invalid and a tag_mem match, giving from_memwb.
- Reset asserted mid-stall: all state clears at once. No stall is pending after release unless mem_stall is asserted.
- Counters wrap never; they saturate.

## Structure
- `hazard_tag_t` (the struct) and the NOP tag constant belong in `rv32i_types`.
- `forward::forward_t` is reused unchanged from the existing package.
- Sub-module `fw_select`: combinational compare of one source against tag_ex and tag_mem, returning forward_t. It is instantiated twice.

## Test plan
- add x5 in ID while tag_ex={1,x5,1,0} → after the edge, alumux1_fw=from_exmem; no stall.
- ID reads x5 and x6; tag_ex writes x5; tag_mem writes x6 → fw1=from_exmem, fw2=from_memwb. If tag_ex and tag_mem both write x5 → fw1=from_exmem (newest wins).
- lw x7 in EX, add x8,x7,x1 in ID:
  - stall_if=stall_id=bubble_ex=1 for one cycle, load_use_cnt=1.
  - The next cycle, with no stall, gives fw1=from_memwb.
- ID rs1=x0 with tag_ex writing rd=0 → fw1=from_idex, no stall.
- flush together with a load-use condition → bubble_ex=1, flush_ifid=1, stall_id=0, flush_cnt=1, load_use_cnt unchanged.
- mem_stall=1 for 3 cycles with a load-use condition present → all tags, selects and counters hold; stall_id=1, bubble_ex=0. Asserting rst mid-freeze → fw=from_idex and counters=0 immediately.
